// File: rtl/onchip_ram_pkg.sv
// Shared types and constants for the two-port on-chip RAM.
// The zero-fill state type is used only when ONCHIP_RAM_CLEAR_EN is defined.
package onchip_ram_pkg;

  typedef enum logic {
    PORT_S1 = 1'b0,
    PORT_S2 = 1'b1
  } port_id;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clear_state_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  function automatic int BE_WIDTH(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/onchip_ram_rr_arb.sv
// Two-way round-robin arbiter. On a tie it grants the port not granted last.
// The pointer moves only on a grant, so a stalled cycle leaves it unchanged.
module onchip_ram_rr_arb
  import onchip_ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  port_id last_reg;

  always_comb begin
    grant = 2'b00;
    if (!stall) begin
      if (req == 2'b11) grant = (last_reg == PORT_S1) ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       last_reg <= PORT_S2;
    else if (|grant) last_reg <= grant[1] ? PORT_S2 : PORT_S1;
  end

endmodule

// File: rtl/maze_accelerometer_onchip_ram_2port.sv
// Single-port RAM shared by two Avalon-MM slaves through a round-robin arbiter,
// with a pipelined read path. Define ONCHIP_RAM_CLEAR_EN to zero-fill after reset.
module maze_accelerometer_onchip_ram_2port
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int DEPTH        = 16384,
  parameter int READ_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clken,
  input  logic                            reset_req,
  input  logic [ADDR_WIDTH-1:0]           s1_address,
  input  logic                            s1_chipselect,
  input  logic                            s1_read,
  input  logic                            s1_write,
  input  logic [BE_WIDTH(DATA_WIDTH)-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]           s1_writedata,
  output logic [DATA_WIDTH-1:0]           s1_readdata,
  output logic                            s1_readdatavalid,
  output logic                            s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]           s2_address,
  input  logic                            s2_chipselect,
  input  logic                            s2_read,
  input  logic                            s2_write,
  input  logic [BE_WIDTH(DATA_WIDTH)-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]           s2_writedata,
  output logic [DATA_WIDTH-1:0]           s2_readdata,
  output logic                            s2_readdatavalid,
  output logic                            s2_waitrequest
);

  localparam int BW    = BE_WIDTH(DATA_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT   = (READ_LATENCY >= READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY_MIN;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [1:0]            cs_v, rd_v, wr_v, req, grant, rdv;
  logic [ADDR_WIDTH-1:0] addr_v  [2];
  logic [BW-1:0]         be_v    [2];
  logic [DATA_WIDTH-1:0] wdata_v [2];
  logic                  stall, clearing, clr_we;
  logic [IDX_W-1:0]      clr_idx;

  assign cs_v       = {s2_chipselect, s1_chipselect};
  assign rd_v       = {s2_read, s1_read};
  assign wr_v       = {s2_write, s1_write};
  assign addr_v[0]  = s1_address;
  assign addr_v[1]  = s2_address;
  assign be_v[0]    = s1_byteenable;
  assign be_v[1]    = s2_byteenable;
  assign wdata_v[0] = s1_writedata;
  assign wdata_v[1] = s2_writedata;
  assign stall      = ~clken | reset_req;

  onchip_ram_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .stall (stall | reset | clearing),
    .req   (req),
    .grant (grant)
  );

  // Accepted access: at most one grant bit is set, grant[1] selects s2.
  logic                  acc_sel, acc_en, acc_wr, acc_rd, acc_in_range;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [IDX_W-1:0]      acc_idx;

  assign acc_sel      = grant[1];
  assign acc_en       = |grant;
  assign acc_addr     = addr_v[acc_sel];
  assign acc_idx      = acc_addr[IDX_W-1:0];
  assign acc_in_range = {1'b0, acc_addr} < DEPTH_W;
  assign acc_wr       = acc_en & wr_v[acc_sel];
  assign acc_rd       = acc_en & ~wr_v[acc_sel];

`ifdef ONCHIP_RAM_CLEAR_EN
  clear_state_t     state_reg, state_next;
  logic [IDX_W-1:0] clr_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (clr_we) clr_cnt_reg <= clr_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLEAR:   if (clr_we && clr_cnt_reg == IDX_W'(DEPTH - 1)) state_next = DONE;
      default: state_next = state_reg;
    endcase
  end

  always_comb begin
    clearing = (state_reg == CLEAR);
    clr_we   = clearing & ~stall & ~reset;
    clr_idx  = clr_cnt_reg;
  end
`else
  assign clearing = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_idx  = '0;
`endif

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [BW-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = acc_idx;
    mem_be    = be_v[acc_sel];
    mem_wdata = wdata_v[acc_sel];
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_idx   = clr_idx;
      mem_be    = '1;
      mem_wdata = '0;
    end else if (acc_wr && acc_in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BW; i++) begin
        if (mem_be[i]) mem[mem_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end
    end
  end

  // Read pipeline: every stage freezes while stalled.
  logic                  st1_valid_reg, st1_port_reg;
  logic [DATA_WIDTH-1:0] st1_data_reg;
  logic                  out_valid, out_port;
  logic [DATA_WIDTH-1:0] out_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      st1_valid_reg <= 1'b0;
      st1_port_reg  <= 1'b0;
      st1_data_reg  <= '0;
    end else if (!stall) begin
      st1_valid_reg <= acc_rd;
      if (acc_rd) begin
        st1_port_reg <= acc_sel;
        st1_data_reg <= acc_in_range ? mem[acc_idx] : '0;
      end
    end
  end

  generate
    if (LAT == 2) begin : g_lat2
      logic                  st2_valid_reg, st2_port_reg;
      logic [DATA_WIDTH-1:0] st2_data_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          st2_valid_reg <= 1'b0;
          st2_port_reg  <= 1'b0;
          st2_data_reg  <= '0;
        end else if (!stall) begin
          st2_valid_reg <= st1_valid_reg;
          if (st1_valid_reg) begin
            st2_port_reg <= st1_port_reg;
            st2_data_reg <= st1_data_reg;
          end
        end
      end

      assign out_valid = st2_valid_reg;
      assign out_port  = st2_port_reg;
      assign out_data  = st2_data_reg;
    end else begin : g_lat1
      assign out_valid = st1_valid_reg;
      assign out_port  = st1_port_reg;
      assign out_data  = st1_data_reg;
    end
  endgenerate

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_port
    assign req[gi] = cs_v[gi] & (rd_v[gi] | wr_v[gi]);
    assign rdv[gi] = out_valid & ~stall & ~reset & (out_port == 1'(gi));
  end

  assign s1_waitrequest   = req[0] & ~grant[0];
  assign s2_waitrequest   = req[1] & ~grant[1];
  assign s1_readdatavalid = rdv[0];
  assign s2_readdatavalid = rdv[1];
  assign s1_readdata      = out_data;
  assign s2_readdata      = out_data;

endmodule

// File: tb/tb_maze_accelerometer_onchip_ram_2port.sv
// Directed bench driving one latency-1 and one latency-2 instance with shared stimulus.
module tb_maze_accelerometer_onchip_ram_2port;

  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, clken, reset_req;
  logic [1:0]    cs, rd, wr;
  logic [AW-1:0] addr  [2];
  logic [3:0]    be    [2];
  logic [31:0]   wdata [2];
  logic [31:0]   rdata1 [2];
  logic [31:0]   rdata2 [2];
  logic [1:0]    rdv1, rdv2, wait1, wait2;

  int checks   = 0;
  int failures = 0;

  maze_accelerometer_onchip_ram_2port #(
    .DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(16), .READ_LATENCY(1)
  ) u_lat1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wdata[0]), .s1_readdata(rdata1[0]),
    .s1_readdatavalid(rdv1[0]), .s1_waitrequest(wait1[0]),
    .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wdata[1]), .s2_readdata(rdata1[1]),
    .s2_readdatavalid(rdv1[1]), .s2_waitrequest(wait1[1])
  );

  maze_accelerometer_onchip_ram_2port #(
    .DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(16), .READ_LATENCY(2)
  ) u_lat2 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wdata[0]), .s1_readdata(rdata2[0]),
    .s1_readdatavalid(rdv2[0]), .s1_waitrequest(wait2[0]),
    .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wdata[1]), .s2_readdata(rdata2[1]),
    .s2_readdatavalid(rdv2[1]), .s2_waitrequest(wait2[1])
  );

  typedef struct {
    int            port;
    bit            write;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    b;
    logic [31:0]   exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit w, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    cs[p] = 1'b1; rd[p] = ~w; wr[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
  endtask

  task automatic release_port(input int p);
    cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
  endtask

  // Returns at the negedge of the accepting cycle; waits counts stalled cycles.
  task automatic wait_grant(input int p, output int waits);
    bit ok = 1'b0;
    waits = 0;
    while (!ok && waits <= 200) begin
      @(negedge clk);
      if (wait1[p] == 1'b0) ok = 1'b1;
      else begin
        waits++;
        next_cycle();
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout port=s%0d waited=%0d required_max=200", p + 1, waits);
    end
  endtask

  task automatic do_write(input int p, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] b);
    int w;
    drive(p, 1'b1, a, d, b);
    wait_grant(p, w);
    next_cycle();
    release_port(p);
    $display("write s%0d addr=%0d data=0x%08h be=%b waits=%0d", p + 1, a, d, b, w);
  endtask

  task automatic do_read(input int p, input logic [AW-1:0] a, input logic [31:0] exp,
                         input string name, output int waits);
    logic [1:0] pv;
    pv = (p == 0) ? 2'b01 : 2'b10;
    drive(p, 1'b0, a, 32'h0, 4'h0);
    wait_grant(p, waits);
    next_cycle();
    release_port(p);
    @(negedge clk);
    check({name, "_lat1_valid"}, 32'(rdv1), 32'(pv));
    check({name, "_lat1_data"}, rdata1[p], exp);
    check({name, "_lat2_early"}, 32'(rdv2), 32'h0);
    next_cycle();
    @(negedge clk);
    check({name, "_lat2_valid"}, 32'(rdv2), 32'(pv));
    check({name, "_lat2_data"}, rdata2[p], exp);
    check({name, "_lat1_single"}, 32'(rdv1), 32'h0);
    next_cycle();
    $display("read  s%0d addr=%0d data=0x%08h exp=0x%08h waits=%0d", p + 1, a, rdata2[p], exp, waits);
  endtask

  logic [1:0]  tie_wait [3] = '{2'b10, 2'b01, 2'b10};
  logic [1:0]  tie_v1   [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
  logic [1:0]  tie_v2   [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
  logic [31:0] tie_d    [2] = '{32'h1111_1111, 32'h2222_2222};
  logic [AW-1:0] st_a   [4] = '{8'd1, 8'd2, 8'd5, 8'd9};
  logic [31:0]   st_d   [4] = '{32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 32'hAA22_AA44};
  int st_i1 [9] = '{-1, 0, 1, 2, -1, -1, 3, -1, -1};
  int st_i2 [9] = '{-1, -1, 0, 1, -1, -1, 2, 3, -1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] exp_after_reset;

    vecs[0]  = '{0, 1'b1, 8'd5,  32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[1]  = '{0, 1'b0, 8'd5,  32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[2]  = '{1, 1'b1, 8'd9,  32'hAAAA_AAAA, 4'hF, 32'h0};
    vecs[3]  = '{0, 1'b1, 8'd9,  32'h1122_3344, 4'h5, 32'h0};
    vecs[4]  = '{1, 1'b0, 8'd9,  32'h0,         4'h0, 32'hAA22_AA44};
    vecs[5]  = '{1, 1'b1, 8'd4,  32'h0BAD_F00D, 4'hF, 32'h0};
    vecs[6]  = '{0, 1'b1, 8'd20, 32'h1234_5678, 4'hF, 32'h0};
    vecs[7]  = '{1, 1'b0, 8'd4,  32'h0,         4'h0, 32'h0BAD_F00D};
    vecs[8]  = '{0, 1'b0, 8'd20, 32'h0,         4'h0, 32'h0};
    vecs[9]  = '{1, 1'b1, 8'd7,  32'h0102_0304, 4'hF, 32'h0};
    vecs[10] = '{0, 1'b1, 8'd7,  32'hFFFF_FFFF, 4'h0, 32'h0};
    vecs[11] = '{0, 1'b0, 8'd7,  32'h0,         4'h0, 32'h0102_0304};
    vecs[12] = '{0, 1'b1, 8'd1,  32'h1111_1111, 4'hF, 32'h0};
    vecs[13] = '{1, 1'b1, 8'd2,  32'h2222_2222, 4'hF, 32'h0};

    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
    cs = '0; rd = '0; wr = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; be[i] = '0; wdata[i] = '0;
    end
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset_valid_lat1", 32'(rdv1), 32'h0);
    check("reset_valid_lat2", 32'(rdv2), 32'h0);
    check("reset_data_lat1", rdata1[0], 32'h0);
    check("reset_data_lat2", rdata2[1], 32'h0);
    check("reset_wait_idle", 32'(wait1), 32'h0);
    next_cycle();
    reset = 1'b0;

`ifdef ONCHIP_RAM_CLEAR_EN
    do_read(0, 8'd3, 32'h0, "clear_read", w);
    check("clear_wait_cycles", 32'(w), 32'd16);
`endif

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].write) begin
        do_write(vecs[i].port, vecs[i].a, vecs[i].d, vecs[i].b);
      end else begin
        do_read(vecs[i].port, vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i), w);
        check($sformatf("vec%0d_wait", i), 32'(w), 32'h0);
      end
    end

    // Tie: pointer was left on s2, so s1 wins first.
    drive(0, 1'b0, 8'd1, 32'h0, 4'h0);
    drive(1, 1'b0, 8'd2, 32'h0, 4'h0);
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin
        release_port(0);
        release_port(1);
      end
      @(negedge clk);
      if (c < 3) check($sformatf("tie_wait_c%0d", c), 32'(wait1), 32'(tie_wait[c]));
      check($sformatf("tie_v1_c%0d", c), 32'(rdv1), 32'(tie_v1[c]));
      check($sformatf("tie_v2_c%0d", c), 32'(rdv2), 32'(tie_v2[c]));
      for (int p = 0; p < 2; p++) begin
        if (tie_v1[c][p]) check($sformatf("tie_d1_c%0d", c), rdata1[p], tie_d[p]);
        if (tie_v2[c][p]) check($sformatf("tie_d2_c%0d", c), rdata2[p], tie_d[p]);
      end
      $display("tie cycle=%0d wait=%b v1=%b v2=%b", c, wait1, rdv1, rdv2);
      next_cycle();
    end

    // Four back-to-back s2 reads, then clken low for two cycles.
    for (int c = 0; c < 9; c++) begin
      if (c < 4) drive(1, 1'b0, st_a[c], 32'h0, 4'h0);
      if (c == 4) begin
        release_port(1);
        clken = 1'b0;
      end
      if (c == 6) clken = 1'b1;
      @(negedge clk);
      if (c < 4) check($sformatf("stall_wait_c%0d", c), 32'(wait1[1]), 32'h0);
      check($sformatf("stall_v1_c%0d", c), 32'(rdv1), (st_i1[c] >= 0) ? 32'h2 : 32'h0);
      check($sformatf("stall_v2_c%0d", c), 32'(rdv2), (st_i2[c] >= 0) ? 32'h2 : 32'h0);
      if (st_i1[c] >= 0) check($sformatf("stall_d1_c%0d", c), rdata1[1], st_d[st_i1[c]]);
      if (st_i2[c] >= 0) check($sformatf("stall_d2_c%0d", c), rdata2[1], st_d[st_i2[c]]);
      if (c == 4) begin
        check("stall_hold_d1", rdata1[1], st_d[3]);
        check("stall_hold_d2", rdata2[1], st_d[2]);
      end
      $display("stall cycle=%0d clken=%b v1=%b v2=%b d2=0x%08h", c, clken, rdv1, rdv2, rdata2[1]);
      next_cycle();
    end

    reset_req = 1'b1;
    drive(0, 1'b0, 8'd5, 32'h0, 4'h0);
    @(negedge clk);
    check("reset_req_wait", 32'(wait1), 32'h1);
    next_cycle();
    reset_req = 1'b0;
    do_read(0, 8'd5, 32'hDEAD_BEEF, "after_reset_req", w);
    check("after_reset_req_waits", 32'(w), 32'h0);

    // Reset one cycle after an accepted read drops it; contents survive.
    drive(0, 1'b0, 8'd5, 32'h0, 4'h0);
    wait_grant(0, w);
    next_cycle();
    release_port(0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_drop_v1", 32'(rdv1), 32'h0);
    check("rst_drop_v2", 32'(rdv2), 32'h0);
    next_cycle();
    drive(1, 1'b0, 8'd9, 32'h0, 4'h0);
    @(negedge clk);
    check("rst_wait", 32'(wait1), 32'h2);
    check("rst_data1", rdata1[0], 32'h0);
    check("rst_data2", rdata2[0], 32'h0);
    next_cycle();
    release_port(1);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("rst_after_v1_c%0d", c), 32'(rdv1), 32'h0);
      check($sformatf("rst_after_v2_c%0d", c), 32'(rdv2), 32'h0);
      next_cycle();
    end
`ifdef ONCHIP_RAM_CLEAR_EN
    exp_after_reset = 32'h0;
`else
    exp_after_reset = 32'hAA22_AA44;
`endif
    do_read(0, 8'd9, exp_after_reset, "rst_keep", w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maze_accelerometer_onchip_ram_2port.md
Name: maze_accelerometer_onchip_ram_2port

Overview:
Parametrised on-chip RAM with two Avalon-MM slave ports, s1 and s2, sharing one single-port array through a round-robin arbiter.
Reads are pipelined, with readdatavalid and configurable latency. Waitrequest back-pressure applies when ports collide or the clock enable stalls the block.
Successor of the fixed 32x16384 single-slave on-chip memory. Sits on the Nios/accelerometer system interconnect as program/data RAM.

Parameters:
DATA_WIDTH, 32, word width; multiple of 8.
ADDR_WIDTH, 14, word-address width per port.
DEPTH, 16384, implemented words; must be <= 2**ADDR_WIDTH.
READ_LATENCY, 1, accepted read to readdatavalid in cycles; legal values 1 or 2.

Ports:
clk  in  1  sole clock
reset  in  1  synchronous, active-high reset
clken  in  1  global clock enable; low = stall
reset_req  in  1  high = stall (reset handshake from the reset controller)
sX_address  in  ADDR_WIDTH  word address (X = 1, 2; every sX port exists per slave)
sX_chipselect  in  1  slave select
sX_read  in  1  read request
sX_write  in  1  write request
sX_byteenable  in  DATA_WIDTH/8  byte lane enables for writes
sX_writedata  in  DATA_WIDTH  write data
sX_readdata  out  DATA_WIDTH  read data; valid only with readdatavalid
sX_readdatavalid  out  1  one-cycle pulse per completed read
sX_waitrequest  out  1  request not accepted this cycle

Behaviour:
- Request: reqX = sX_chipselect & (sX_read | sX_write). If read and write are both high, the request is a write; the read is ignored.
- Stall: stall = ~clken | reset_req.
- Grant:
  - No grants while stall or reset is high.
  - Otherwise a sole requester is granted.
  - On a tie, the port not granted last wins.
  - The last-grant pointer updates only on a grant. Reset value = s2, so s1 wins the first tie.
- sX_waitrequest = reqX & ~grantX, combinational. It is 0 when not requesting.
- Accept: an access is accepted at the rising edge where reqX & grantX.
- Write:
  - Lanes with byteenable=1 update at the accepting edge; other lanes are unchanged.
  - byteenable=0 means the access is accepted with no change.
- Read:
  - READ_LATENCY=1: sX_readdatavalid is high in the cycle right after the accepting edge.
  - READ_LATENCY=2: it is high one cycle later.
  - Data is registered. Back-to-back reads give back-to-back valids, in order.
  - At most one port has readdatavalid high per cycle.
- Ordering: the array is single-port with one access per cycle. A read after a write to the same address, on either port, returns the new data.
- Out of range (address >= DEPTH): writes are dropped. Reads complete normally and return 0.
- Stall mid-pipeline: all in-flight pipeline stages and readdata hold. readdatavalid is forced low while stalled and reasserts with the held data on the first non-stall cycle.
- Reset:
  - Pipeline valid bits clear; in-flight reads are dropped.
  - readdata = 0, readdatavalid = 0, pointer = s2.
  - waitrequest follows its equation, so any requester sees 1 during reset.
  - RAM contents are preserved.

Optional Feature:
ONCHIP_RAM_CLEAR_EN
- Defined:
  - Zero-fill FSM with states IDLE, CLEAR, DONE. Reset forces CLEAR with counter = 0.
  - In CLEAR, one word per cycle is written with all-zero data, counter 0..DEPTH-1. After the last word the FSM goes to DONE.
  - Counter advances only when not stalled.
  - While in CLEAR: no grants, so any requester sees waitrequest=1, and readdatavalid=0.
  - Reset mid-clear restarts the clear at address 0.
  - Clear completes DEPTH unstalled cycles after reset falls.
- Not defined: no FSM. Contents are undefined at power-up and requests are served from the first cycle after reset.

Decomposition:
- Package onchip_ram_pkg:
  - port_id enum (PORT_S1, PORT_S2)
  - clear_state_t (IDLE/CLEAR/DONE)
  - legal READ_LATENCY bounds
  - BE_WIDTH function
- Sub-module onchip_ram_rr_arb: 2-way round-robin arbiter with grant vector and pointer. Pointer update is gated by stall.

Test Plan:
1. READ_LATENCY=1: s1 writes 0xDEADBEEF to addr 5, then reads addr 5 -> waitrequest 0 on both; readdatavalid 1 cycle after accept; readdata=0xDEADBEEF.
2. Byte lanes: write 0x11223344 with byteenable=4'b0101 over 0xAAAAAAAA at addr 9 -> read returns 0xAA22AA44.
3. Tie: s1 and s2 read simultaneously for 3 cycles -> grants s1, s2, s1; the losing port sees waitrequest=1 each cycle; valids arrive in the same order.
4. READ_LATENCY=2: 4 back-to-back s2 reads, then clken low for 2 cycles mid-pipeline -> valids suppressed while stalled, then resume in order with no data lost.
5. Reset asserted 1 cycle after a read is accepted -> no readdatavalid; an earlier written word is still readable after reset.
6. ONCHIP_RAM_CLEAR_EN with DEPTH=16: s1 reads addr 3 right after reset -> waitrequest held 16 cycles; the read then returns 0.
